reaction_judge: RTL and testbench
=================================

# reaction_judge

Player-input judge for the reaction game. It lights one target LED chosen pseudo-randomly, debounces the eight player buttons, and judges each round as a hit or a miss. It emits a clean one-cycle `miss` pulse to the countdown timer, which applies the time penalty. It stops judging once the timer raises `game_over`.

## Interface
Parameters:
- `NUM_BTN`, 8: buttons/LEDs; target index width is 3.
- `DEBOUNCE_CYCLES`, 500000: debounce sample period (10 ms at 50 MHz).
- `WINDOW_CYCLES`, 50000000: response window per round (1 s).
- `SCORE_W`, 10: score width.

Ports:
- `clock`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  synchronous one-cycle pulse; leaves IDLE.
- `btn`  in  NUM_BTN  raw asynchronous buttons, active-high.
- `game_over`  in  1  level from timer; freezes the block.
- `led`  out  NUM_BTN  one-hot target; all-zero when no round is active.
- `hit`  out  1  one-cycle pulse per correct press.
- `miss`  out  1  one-cycle registered pulse per wrong press or timeout; feeds the timer.
- `score`  out  SCORE_W  hits, saturating.
- `miss_count`  out  8  misses, saturating at 255.
- `busy`  out  1  high in ARM/WAIT/COOLDOWN.

## Operation
- Reset values: all outputs 0; state IDLE; LFSR = 16'hACE1; previous target = 0.
- Input path: `btn` → 2-flop synchroniser → debouncer.
  - Shared tick every DEBOUNCE_CYCLES.
  - Debounced bit updates when two consecutive tick samples agree.
- Press event: rising edge of any debounced bit; one-cycle vector `press`.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, steps every cycle from reset.
- States:
  - IDLE: `led`=0. Goes to ARM on `start`.
  - ARM (1 cycle): target = LFSR[2:0]. If that equals the previous target, use (LFSR[2:0]+1) mod 8. Clear window counter → WAIT.
  - WAIT: `led` = one-hot(target); window counter increments each cycle.
    - `press` one-hot and equal to target → hit.
    - Any other nonzero `press` (wrong bit, or several bits) → miss.
    - Counter reaches WINDOW_CYCLES-1 with no press → miss.
    - A press and the timeout in the same cycle: the press is judged, the timeout is ignored.
    - After a hit or miss → COOLDOWN.
  - COOLDOWN: `led`=0. Leaves when the debounced vector is all-zero → ARM.
  - OVER: `led`=0, `busy`=0, no pulses. Exits only on reset.
- On a hit: `score` +1, saturating at 2^SCORE_W-1.
- On a miss: `miss_count` +1, saturating at 255.
- `game_over` high in any state → OVER on the next edge.
  - It takes priority over a same-cycle judgement: no `hit`/`miss` and no counter update.
  - `score` and `miss_count` hold in OVER.
- Presses outside WAIT are discarded. They are never queued.
- `start` outside IDLE is ignored.

## Timing
- `btn` edge → `press`: 2 sync cycles + 1–2 debounce ticks.
- `press` in WAIT at cycle N → at edge N+1: `hit`/`miss` high, counter updated, state = COOLDOWN, `led`=0. Pulse drops at N+2.
- Timeout: the pulse comes WINDOW_CYCLES cycles after the first WAIT cycle.
- ARM→WAIT: `led` becomes valid 1 cycle after entering ARM.
- Minimum `miss` spacing is 3 cycles (WAIT→COOLDOWN→ARM→WAIT). The timer therefore sees distinct pulses.
- `hit` and `miss` are never high together.

## Structure
- `game_pkg` holds:
  - state encoding: IDLE, ARM, WAIT, COOLDOWN, OVER;
  - LFSR seed and taps;
  - NUM_BTN.
- Sub-module `btn_debounce` (parameterised by NUM_BTN and DEBOUNCE_CYCLES): synchroniser, tick counter, per-bit agreement, rising-edge `press` output.
- Top level contains the LFSR, the FSM, the window counter and the saturating counters.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, WINDOW_CYCLES=100.
- Reset, then `start`, target shown, correct button held 20 cycles and released → one `hit` pulse, `score`=1, `miss_count`=0, then a new `led` that differs from the previous one.
- Wrong button pressed in WAIT → exactly one `miss` pulse, `miss_count`=1, `led`=0 until release.
- No press → `miss` exactly 100 cycles after WAIT entry; `led` rearms after COOLDOWN.
- Two buttons pressed on the same cycle, including the target → `miss`, not `hit`.
- Button bouncing every 2 cycles for 30 cycles, then stable → a single `press` event.
- `game_over` asserted on the same cycle as a correct `press` → no `hit`, `score` unchanged, `led`=0, later presses ignored.
- Mid-WAIT `reset_n` low → all outputs 0 immediately (asynchronous); after release, state is IDLE.
- 256 forced misses → `miss_count` saturates at 255.

Source files
------------

// File: rtl/reaction_judge_pkg.sv
// game_pkg: shared definitions for the reaction game judge.
//   - state encoding of the round FSM
//   - LFSR seed and Galois toggle mask for x^16+x^14+x^13+x^11+1
//   - default button/LED count and target index width
//   - lfsrStep(): one shift of the right-shifting Galois LFSR
package game_pkg;

   localparam int NUM_BTN  = 8;
   localparam int TARGET_W = 3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Galois form: feedback bit enters at bit 15 and toggles
   // the bits that correspond to the x^14, x^13 and x^11 terms.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT,
      COOLDOWN,
      OVER
   } state_t;

   function automatic logic [15:0] lfsrStep(input logic [15:0] value);
      return {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/reaction_judge_if.sv
// reaction_judge_if: player/timer-facing signals of the reaction judge.
//   start      : one-cycle pulse that begins a game from IDLE
//   btn        : raw asynchronous buttons, active-high
//   game_over  : level from the countdown timer, freezes the judge
//   led        : one-hot target, zero while no round is active
//   hit / miss : one-cycle judgement pulses (miss feeds the timer)
//   score      : saturating hit counter
//   miss_count : saturating miss counter
//   busy       : a round is in progress (ARM/WAIT/COOLDOWN)
// master = player/timer side, slave = the judge.
interface reaction_judge_if #(
   parameter int NUM_BTN = 8,
   parameter int SCORE_W = 10
);

   logic               start;
   logic [NUM_BTN-1:0] btn;
   logic               game_over;
   logic [NUM_BTN-1:0] led;
   logic               hit;
   logic               miss;
   logic [SCORE_W-1:0] score;
   logic [7:0]         miss_count;
   logic               busy;

   modport master (
      output start, btn, game_over,
      input  led, hit, miss, score, miss_count, busy
   );

   modport slave (
      input  start, btn, game_over,
      output led, hit, miss, score, miss_count, busy
   );

endinterface

// File: rtl/reaction_judge_btn_debounce.sv
// btn_debounce: cleans up the raw player buttons.
//   clock, reset_n : system clock, asynchronous active-low reset
//   i_btn          : raw asynchronous buttons
//   o_debounced    : debounced button levels
//   o_press        : one-cycle pulse per rising edge of a debounced bit
// A single tick counter is shared by all bits; a debounced bit only moves
// when two consecutive tick samples agree on the new level.
module btn_debounce #(
   parameter int NUM_BTN         = 8,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_BTN-1:0] i_btn,
   output logic [NUM_BTN-1:0] o_debounced,
   output logic [NUM_BTN-1:0] o_press
);

   localparam int TICK_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTN-1:0] r_sync1;
   logic [NUM_BTN-1:0] r_sync2;
   logic [NUM_BTN-1:0] r_sample;
   logic [NUM_BTN-1:0] r_debounced;
   logic [NUM_BTN-1:0] r_debouncedPrev;
   logic [TICK_W-1:0]  r_tickCnt;
   logic               w_tick;
   logic [NUM_BTN-1:0] w_agree;

   assign w_tick  = (r_tickCnt == TICK_LAST);
   assign w_agree = ~(r_sync2 ^ r_sample);

   // Two-flop synchroniser brings the asynchronous buttons into the clock domain.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Free-running sample tick shared by every button.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_tickCnt <= '0;
      end else if (w_tick) begin
         r_tickCnt <= '0;
      end else begin
         r_tickCnt <= r_tickCnt + TICK_W'(1);
      end
   end

   // On each tick, bits whose new sample matches the previous tick's sample
   // take that level; disagreeing bits keep their debounced value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sample    <= '0;
         r_debounced <= '0;
      end else if (w_tick) begin
         r_sample    <= r_sync2;
         r_debounced <= (w_agree & r_sync2) | (~w_agree & r_debounced);
      end
   end

   // One-cycle history of the debounced levels for edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_debouncedPrev <= '0;
      end else begin
         r_debouncedPrev <= r_debounced;
      end
   end

   assign o_debounced = r_debounced;
   assign o_press     = r_debounced & ~r_debouncedPrev;

endmodule

// File: rtl/reaction_judge.sv
// reaction_judge: lights a pseudo-random target LED, judges each debounced
// button press as a hit or a miss, and counts both with saturation.
//   clock, reset_n : 50 MHz system clock, asynchronous active-low reset
//   bus            : reaction_judge_if.slave (start, btn, game_over in;
//                    led, hit, miss, score, miss_count, busy out)
// game_over from the timer overrides everything and parks the FSM in OVER
// until reset.
module reaction_judge #(
   parameter int NUM_BTN         = game_pkg::NUM_BTN,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int WINDOW_CYCLES   = 50000000,
   parameter int SCORE_W         = 10
) (
   input logic             clock,
   input logic             reset_n,
   reaction_judge_if.slave bus
);

   import game_pkg::*;

   localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

   state_t              r_state;
   state_t              w_stateNext;
   logic [15:0]         r_lfsr;
   logic [TARGET_W-1:0] r_target;
   logic [TARGET_W-1:0] r_prevTarget;
   logic [TARGET_W-1:0] w_armTarget;
   logic [WIN_W-1:0]    r_windowCnt;
   logic                r_hit;
   logic                r_miss;
   logic                w_hitNext;
   logic                w_missNext;
   logic [SCORE_W-1:0]  r_score;
   logic [7:0]          r_missCount;
   logic [NUM_BTN-1:0]  w_press;
   logic [NUM_BTN-1:0]  w_debounced;
   logic [NUM_BTN-1:0]  w_targetMask;

   btn_debounce #(
      .NUM_BTN        (NUM_BTN),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) uDebounce (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_btn      (bus.btn),
      .o_debounced(w_debounced),
      .o_press    (w_press)
   );

   // Never repeat the previous target: bump a colliding pick to the next LED.
   assign w_armTarget  = (r_lfsr[TARGET_W-1:0] == r_prevTarget) ?
                         r_lfsr[TARGET_W-1:0] + TARGET_W'(1) : r_lfsr[TARGET_W-1:0];
   assign w_targetMask = NUM_BTN'(1) << r_target;

   // LFSR runs every cycle from reset so the target depends on player timing.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= lfsrStep(r_lfsr);
      end
   end

   // State register plus the registered judgement pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_hit   <= 1'b0;
         r_miss  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_hit   <= w_hitNext;
         r_miss  <= w_missNext;
      end
   end

   // Next-state and judgement logic. game_over wins over any same-cycle
   // judgement; a press wins over a same-cycle window timeout.
   always_comb begin
      w_stateNext = r_state;
      w_hitNext   = 1'b0;
      w_missNext  = 1'b0;
      if (bus.game_over) begin
         w_stateNext = OVER;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  w_stateNext = ARM;
               end
            end
            ARM: begin
               w_stateNext = WAIT;
            end
            WAIT: begin
               if (w_press != '0) begin
                  if (w_press == w_targetMask) begin
                     w_hitNext = 1'b1;
                  end else begin
                     w_missNext = 1'b1;
                  end
                  w_stateNext = COOLDOWN;
               end else if (r_windowCnt == WIN_LAST) begin
                  w_missNext  = 1'b1;
                  w_stateNext = COOLDOWN;
               end
            end
            COOLDOWN: begin
               if (w_debounced == '0) begin
                  w_stateNext = ARM;
               end
            end
            OVER: begin
               w_stateNext = OVER;
            end
            default: begin
               w_stateNext = IDLE;
            end
         endcase
      end
   end

   // Target is latched in ARM and remembered for the next round's collision check.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_target     <= '0;
         r_prevTarget <= '0;
      end else if (r_state == ARM) begin
         r_target     <= w_armTarget;
         r_prevTarget <= w_armTarget;
      end
   end

   // Response window: cleared in ARM, counts every WAIT cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_windowCnt <= '0;
      end else if (r_state == ARM) begin
         r_windowCnt <= '0;
      end else if (r_state == WAIT) begin
         r_windowCnt <= r_windowCnt + WIN_W'(1);
      end
   end

   // Saturating hit and miss counters, updated together with the pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_score     <= '0;
         r_missCount <= '0;
      end else begin
         if (w_hitNext && (r_score != '1)) begin
            r_score <= r_score + SCORE_W'(1);
         end
         if (w_missNext && (r_missCount != 8'hFF)) begin
            r_missCount <= r_missCount + 8'd1;
         end
      end
   end

   assign bus.led        = (r_state == WAIT) ? w_targetMask : '0;
   assign bus.hit        = r_hit;
   assign bus.miss       = r_miss;
   assign bus.score      = r_score;
   assign bus.miss_count = r_missCount;
   assign bus.busy       = (r_state == ARM) || (r_state == WAIT) || (r_state == COOLDOWN);

endmodule

// File: tb/tb_reaction_judge.sv
// tb_reaction_judge: scoreboard bench for reaction_judge.
// Stimulus pushes the expected judgement of each round into a queue; a
// negedge monitor pops it whenever hit/miss pulses and checks the counters.
// The monitor also predicts each target LED from a reference LFSR.
module tb_reaction_judge;

   localparam int NB  = 8;
   localparam int SW  = 10;
   localparam int DEB = 4;
   localparam int WIN = 100;

   typedef struct {
      bit isHit;
      bit isTimeout;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   int passCount  = 0;
   int checkCount = 0;

   exp_t        expQ[$];
   exp_t        expItem;
   logic [15:0] mLfsr;
   logic [15:0] lfsrLastNeg = 16'h0000;
   logic [7:0]  ledLast = 8'h00;
   logic [2:0]  mTarget = 3'd0;
   logic [2:0]  mPrevTarget = 3'd0;
   logic [2:0]  mPick;
   int          cycleCount = 0;
   int          waitEntry = 0;
   int          expScore = 0;
   int          expMiss = 0;

   reaction_judge_if #(.NUM_BTN(NB), .SCORE_W(SW)) bus ();

   reaction_judge #(
      .NUM_BTN        (NB),
      .DEBOUNCE_CYCLES(DEB),
      .WINDOW_CYCLES  (WIN),
      .SCORE_W        (SW)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   // Reference LFSR from the game's polynomial x^16+x^14+x^13+x^11+1.
   function automatic logic [15:0] refLfsrNext(input logic [15:0] v);
      int x;
      int outBit;
      x      = int'(v);
      outBit = x % 2;
      x      = x / 2;
      if (outBit == 1) x = x ^ 32'h0000_B400;
      return x[15:0];
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) mLfsr <= 16'hACE1;
      else          mLfsr <= refLfsrNext(mLfsr);
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Monitor: predicts each new target and scores every judgement pulse.
   always @(negedge clock) begin
      cycleCount++;
      if (!reset_n) begin
         mPrevTarget = 3'd0;
         expScore    = 0;
         expMiss     = 0;
         expQ.delete();
      end else begin
         if ((ledLast == 8'h00) && (bus.led != 8'h00)) begin
            mPick = lfsrLastNeg[2:0];
            if (mPick == mPrevTarget) mPick = mPick + 3'd1;
            mTarget     = mPick;
            mPrevTarget = mPick;
            waitEntry   = cycleCount;
            checkOutput("led_target", int'(bus.led), int'(8'(1) << mPick));
         end
         if (bus.hit || bus.miss) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_pulse", int'({bus.hit, bus.miss}), 0);
            end else begin
               expItem = expQ.pop_front();
               checkOutput("pulse_kind", int'({bus.hit, bus.miss}), expItem.isHit ? 2 : 1);
               if (expItem.isTimeout) checkOutput("timeout_delay", cycleCount - waitEntry, WIN);
               if (expItem.isHit) begin
                  if (expScore < 1023) expScore++;
               end else begin
                  if (expMiss < 255) expMiss++;
               end
               checkOutput("score", int'(bus.score), expScore);
               checkOutput("miss_count", int'(bus.miss_count), expMiss);
            end
         end
      end
      ledLast     = bus.led;
      lfsrLastNeg = mLfsr;
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_led"}, int'(bus.led), 0);
      checkOutput({tag, "_hit"}, int'(bus.hit), 0);
      checkOutput({tag, "_miss"}, int'(bus.miss), 0);
      checkOutput({tag, "_score"}, int'(bus.score), 0);
      checkOutput({tag, "_miss_count"}, int'(bus.miss_count), 0);
      checkOutput({tag, "_busy"}, int'(bus.busy), 0);
   endtask

   task automatic doReset();
      bus.start     = 1'b0;
      bus.btn       = '0;
      bus.game_over = 1'b0;
      reset_n       = 1'b0;
      repeat (3) @(negedge clock);
      checkAllZero("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic pulseStart();
      @(negedge clock);
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic waitForLed(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (bus.led != 8'h00) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("led_armed", int'(bus.led != 8'h00), 1);
      #1;
   endtask

   task automatic waitDrain(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (expQ.size() == 0) break;
         @(negedge clock);
      end
      checkOutput("pending_expectations", expQ.size(), 0);
   endtask

   task automatic applyStimulus(input logic [7:0] mask, input int hold, input int after);
      bus.btn = mask;
      repeat (hold) @(negedge clock);
      bus.btn = '0;
      repeat (after) @(negedge clock);
   endtask

   // kind: 0 correct press, 1 wrong single button, 2 target plus another, 3 no press
   task automatic playRound(input int kind);
      bit         ok;
      logic [7:0] tmask;
      logic [7:0] mask;
      logic [2:0] other;
      waitForLed(ok);
      if (!ok) return;
      tmask = 8'(1) << mTarget;
      other = mTarget + 3'($urandom_range(1, 7));
      mask  = 8'h00;
      case (kind)
         0: begin
            expQ.push_back('{isHit: 1'b1, isTimeout: 1'b0});
            mask = tmask;
         end
         1: begin
            expQ.push_back('{isHit: 1'b0, isTimeout: 1'b0});
            mask = 8'(1) << other;
         end
         2: begin
            expQ.push_back('{isHit: 1'b0, isTimeout: 1'b0});
            mask = tmask | (8'(1) << other);
         end
         default: begin
            expQ.push_back('{isHit: 1'b0, isTimeout: 1'b1});
         end
      endcase
      if (mask != 8'h00) applyStimulus(mask, 16, 14);
      waitDrain(200);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit         ok;
      bit         found;
      logic [7:0] tmask;
      logic [7:0] firstLed;
      logic [2:0] other;

      bus.start     = 1'b0;
      bus.btn       = '0;
      bus.game_over = 1'b0;
      #1;
      doReset();

      $display("[TB] correct press");
      pulseStart();
      waitForLed(ok);
      tmask    = 8'(1) << mTarget;
      firstLed = tmask;
      expQ.push_back('{isHit: 1'b1, isTimeout: 1'b0});
      applyStimulus(tmask, 20, 16);
      waitDrain(100);
      checkOutput("score_after_hit", int'(bus.score), 1);
      checkOutput("miss_after_hit", int'(bus.miss_count), 0);
      waitForLed(ok);
      checkOutput("led_changed", int'(bus.led != firstLed), 1);

      $display("[TB] wrong press held");
      other = mTarget + 3'd3;
      expQ.push_back('{isHit: 1'b0, isTimeout: 1'b0});
      bus.btn = 8'(1) << other;
      repeat (20) @(negedge clock);
      checkOutput("led_off_while_held", int'(bus.led), 0);
      checkOutput("busy_while_held", int'(bus.busy), 1);
      checkOutput("miss_after_wrong", int'(bus.miss_count), 1);
      bus.btn = '0;
      repeat (16) @(negedge clock);
      waitDrain(100);

      $display("[TB] timeout");
      playRound(3);

      $display("[TB] two buttons including target");
      playRound(2);

      $display("[TB] bouncing button");
      waitForLed(ok);
      tmask = 8'(1) << mTarget;
      expQ.push_back('{isHit: 1'b1, isTimeout: 1'b0});
      for (int i = 0; i < 15; i++) begin
         bus.btn = (i % 2 == 0) ? tmask : 8'h00;
         repeat (2) @(negedge clock);
      end
      bus.btn = tmask;
      repeat (20) @(negedge clock);
      bus.btn = '0;
      repeat (16) @(negedge clock);
      waitDrain(100);

      $display("[TB] random rounds");
      for (int r = 0; r < 24; r++) playRound(int'($urandom_range(0, 3)));

      $display("[TB] game_over with same-cycle press");
      waitForLed(ok);
      tmask   = 8'(1) << mTarget;
      found   = 1'b0;
      bus.btn = tmask;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (dut.uDebounce.o_press != 8'h00) begin
            found = 1'b1;
            break;
         end
      end
      bus.game_over = 1'b1;
      checkOutput("press_seen", int'(found), 1);
      repeat (3) @(negedge clock);
      checkOutput("over_led", int'(bus.led), 0);
      checkOutput("over_busy", int'(bus.busy), 0);
      checkOutput("over_score", int'(bus.score), expScore);
      bus.btn = '0;
      repeat (16) @(negedge clock);
      applyStimulus(tmask, 16, 14);
      pulseStart();
      repeat (10) @(negedge clock);
      checkOutput("over_score_hold", int'(bus.score), expScore);
      checkOutput("over_miss_hold", int'(bus.miss_count), expMiss);
      checkOutput("over_led_hold", int'(bus.led), 0);

      $display("[TB] asynchronous reset mid-WAIT");
      doReset();
      pulseStart();
      playRound(0);
      waitForLed(ok);
      repeat (10) @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      checkOutput("idle_after_reset_busy", int'(bus.busy), 0);
      checkOutput("idle_after_reset_led", int'(bus.led), 0);

      $display("[TB] miss saturation");
      pulseStart();
      for (int r = 0; r < 256; r++) playRound(1 + int'($urandom_range(0, 1)));
      checkOutput("miss_saturated", int'(bus.miss_count), 255);
      checkOutput("score_after_misses", int'(bus.score), 0);

      repeat (5) @(negedge clock);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
